// File: rtl/acc_sequencer.sv
// Accumulator sequencer that drives an external combinational adder through a
// fixed IDLE -> EXEC -> DONE cycle and keeps ALU-style C/Z/N/V flags.
module acc_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             res_valid,
    output logic [1:0]       fsm_state
);

    // Handshake: a request transfers on a rising edge where op_valid && op_ready;
    // op_ready is high only in IDLE, and requests seen in other states are dropped.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SBB  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;

    state_t            state;
    state_t            state_next;
    logic [2:0]        op_code_q;
    logic [WIDTH-1:0]  op_data_q;
    logic              accept;
    logic              is_arith;
    logic [WIDTH-1:0]  b_sel;
    logic              cin_sel;

    logic              wb_acc_en;
    logic              wb_cv_en;
    logic [WIDTH-1:0]  wb_acc;
    logic              wb_c;
    logic              wb_v;

    assign op_ready  = (state == IDLE);
    assign res_valid = (state == DONE);
    assign fsm_state = state;
    assign accept    = op_valid && op_ready;
    assign is_arith  = (op_code[2] == 1'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + cin, so the flag register holds NOT borrow.
    always_comb begin
        b_sel   = op_data;
        cin_sel = 1'b0;
        case (op_code)
            OP_ADD: begin
                b_sel   = op_data;
                cin_sel = 1'b0;
            end
            OP_ADC: begin
                b_sel   = op_data;
                cin_sel = flag_c;
            end
            OP_SUB: begin
                b_sel   = ~op_data;
                cin_sel = 1'b1;
            end
            OP_SBB: begin
                b_sel   = ~op_data;
                cin_sel = flag_c;
            end
            default: begin
                b_sel   = op_data;
                cin_sel = 1'b0;
            end
        endcase
    end

    always_comb begin
        wb_acc_en = 1'b0;
        wb_cv_en  = 1'b0;
        wb_acc    = acc;
        wb_c      = flag_c;
        wb_v      = flag_v;
        case (op_code_q)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                wb_acc_en = 1'b1;
                wb_cv_en  = 1'b1;
                wb_acc    = add_sum;
                wb_c      = add_cout;
                wb_v      = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != add_a[WIDTH-1]);
            end
            OP_LOAD: begin
                wb_acc_en = 1'b1;
                wb_acc    = op_data_q;
            end
            OP_CLR: begin
                wb_acc_en = 1'b1;
                wb_acc    = '0;
            end
            default: begin
                wb_acc_en = 1'b0;
            end
        endcase
    end

    // Adder operands are only reloaded for arithmetic ops and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_code_q <= 3'b110;
            op_data_q <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
        end else if (accept) begin
            op_code_q <= op_code;
            op_data_q <= op_data;
            if (is_arith) begin
                add_a   <= acc;
                add_b   <= b_sel;
                add_cin <= cin_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (state == EXEC) begin
            if (wb_acc_en) begin
                acc    <= wb_acc;
                flag_z <= (wb_acc == '0);
                flag_n <= wb_acc[WIDTH-1];
            end
            if (wb_cv_en) begin
                flag_c <= wb_c;
                flag_v <= wb_v;
            end
        end
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: a behavioural accumulator model predicts
// each result, and a negedge monitor checks every res_valid pulse against it.
module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_data;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic [7:0] acc;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;
  logic       res_valid;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  // Stand-in for the external combinational adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  acc_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_data   (op_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .acc       (acc),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .res_valid (res_valid),
    .fsm_state (fsm_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // Reference model state
  logic [7:0] m_acc;
  logic       m_c, m_z, m_n, m_v;
  int         next_free;

  // Scoreboard: packed {acc, c, z, n, v} and the cycle it must appear in
  logic [11:0] exp_q[$];
  int          exp_cyc_q[$];

  logic        add_chk_valid = 1'b0;
  int          add_chk_cyc;
  logic [7:0]  exp_add_a, exp_add_b;
  logic        exp_add_cin;
  int          rst_chk_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_acc = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
  endtask

  // Accumulator semantics in plain integer arithmetic.
  task automatic model_apply(input logic [2:0] code, input logic [7:0] data);
    int a_s, d_s, carry_in, u, s;
    a_s = m_acc[7] ? int'(m_acc) - 256 : int'(m_acc);
    d_s = data[7]  ? int'(data) - 256  : int'(data);
    carry_in = m_c ? 1 : 0;
    case (code)
      3'd0, 3'd1: begin
        if (code == 3'd0) carry_in = 0;
        u = int'(m_acc) + int'(data) + carry_in;
        s = a_s + d_s + carry_in;
        m_c = (u > 255);
        m_v = (s > 127) || (s < -128);
        m_acc = u[7:0];
      end
      3'd2, 3'd3: begin
        // borrow is the complement of the stored carry
        if (code == 3'd2) carry_in = 1;
        u = int'(m_acc) - int'(data) - (1 - carry_in);
        s = a_s - d_s - (1 - carry_in);
        m_c = (u >= 0);
        m_v = (s > 127) || (s < -128);
        m_acc = u[7:0];
      end
      3'd4: m_acc = data;
      3'd5: m_acc = 8'h00;
      default: ;
    endcase
    if (code <= 3'd5) begin
      m_z = (m_acc == 8'h00);
      m_n = m_acc[7];
    end
  endtask

  // One clock of stimulus; acceptance is decided by the model, not by op_ready.
  task automatic drive_cycle(input logic v, input logic [2:0] code, input logic [7:0] data,
                             input logic r);
    @(negedge clk);
    op_valid = v;
    op_code  = code;
    op_data  = data;
    rst      = r;
    if (r) begin
      exp_q.delete();
      exp_cyc_q.delete();
      model_reset();
      next_free   = cyc + 1;
      rst_chk_cyc = cyc + 1;
    end else begin
      check("op_ready", {31'd0, op_ready}, {31'd0, cyc >= next_free});
      if (v && cyc >= next_free) begin
        if (code <= 3'd3) begin
          exp_add_a     = m_acc;
          exp_add_b     = code[1] ? ~data : data;
          exp_add_cin   = (code == 3'd0) ? 1'b0 : (code == 3'd2) ? 1'b1 : m_c;
          add_chk_valid = 1'b1;
          add_chk_cyc   = cyc + 1;
        end
        model_apply(code, data);
        exp_q.push_back({m_acc, m_c, m_z, m_n, m_v});
        exp_cyc_q.push_back(cyc + 2);
        next_free = cyc + 3;
      end
    end
  endtask

  task automatic do_op(input logic [2:0] code, input logic [7:0] data);
    drive_cycle(1'b1, code, data, 1'b0);
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b0);
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (add_chk_valid && cyc == add_chk_cyc) begin
      check("add_a", {24'd0, add_a}, {24'd0, exp_add_a});
      check("add_b", {24'd0, add_b}, {24'd0, exp_add_b});
      check("add_cin", {31'd0, add_cin}, {31'd0, exp_add_cin});
      add_chk_valid = 1'b0;
    end
    if (cyc == rst_chk_cyc) begin
      check("reset_state", {19'd0, acc, flag_c, flag_z, flag_n, flag_v, res_valid},
            32'd0);
      check("reset_adder", {15'd0, add_a, add_b, add_cin}, 32'd0);
      check("reset_ready", {31'd0, op_ready}, 32'd1);
    end
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc && res_valid !== 1'b1) begin
      check("res_valid_missing", {31'd0, res_valid}, 32'd1);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end else if (res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("res_valid_unexpected", {31'd0, res_valid}, 32'd0);
      end else begin
        check("res_latency", cyc, exp_cyc_q.pop_front());
        check("acc_flags", {20'd0, acc, flag_c, flag_z, flag_n, flag_v},
              {20'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_data = 8'h00;
    model_reset();
    next_free = 0;
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b1);
    drive_cycle(1'b1, 3'd0, 8'h11, 1'b1);   // reset beats a simultaneous request
    idle(2);

    do_op(3'd4, 8'hAA); do_op(3'd0, 8'h43);
    do_op(3'd4, 8'hFF); do_op(3'd0, 8'hFF); do_op(3'd1, 8'h01);
    do_op(3'd4, 8'h7F); do_op(3'd0, 8'h01);
    do_op(3'd4, 8'h01); do_op(3'd2, 8'h01); do_op(3'd2, 8'h01);
    do_op(3'd3, 8'h10); do_op(3'd5, 8'h00);
    do_op(3'd4, 8'h80); do_op(3'd6, 8'h00); do_op(3'd7, 8'h33);

    // continuous request stream: one transfer per three cycles
    for (int i = 0; i < 15; i++) drive_cycle(1'b1, 3'($urandom_range(0, 3)), 8'($urandom), 1'b0);
    idle(3);

    // reset during EXEC of an ADD aborts it
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b1);
    idle(1);
    drive_cycle(1'b1, 3'd0, 8'h55, 1'b0);
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b1);
    idle(4);

    for (int i = 0; i < 300; i++)
      drive_cycle($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
    idle(5);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
